// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that owns HI/LO.
// Results are computed when the operation starts and are committed to HI/LO
// after a fixed latency, while busy drives the decode-stage stall request.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall_req
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        start_mc;
  logic        div_zero;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [32:0] dvd_s;
  logic signed [32:0] dvs_s;
  logic signed [32:0] quo_s;
  logic signed [32:0] rem_s;
  logic [31:0] dvs_u;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Stall decode whenever it needs HI/LO while an operation is starting or running.
  always_comb begin
    start_mc  = start && (md_op <= 3'd3);
    stall_req = d_is_md && (busy || start_mc);
  end

  // Products and quotients of the current operands, captured into the pending result at start.
  always_comb begin
    div_zero = (src_b == '0);
    prod_u   = {32'b0, src_a} * {32'b0, src_b};
    prod_s   = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    // 33-bit signed division makes 0x80000000 / -1 yield +2^31, whose low
    // 32 bits are the required 0x80000000 with no overflow special case.
    dvd_s    = $signed({src_a[31], src_a});
    dvs_s    = div_zero ? 33'sd1 : $signed({src_b[31], src_b});
    quo_s    = dvd_s / dvs_s;
    rem_s    = dvd_s % dvs_s;
    dvs_u    = div_zero ? 32'd1 : src_b;
    quo_u    = src_a / dvs_u;
    rem_u    = src_a % dvs_u;
  end

  // Operation sequencer: IDLE accepts work, RUN counts down and commits the pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op_t'(md_op))
              OP_MULT: begin
                {pend_hi, pend_lo} <= prod_s;
                pend_wr <= 1'b1;
                cnt     <= 4'(MUL_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MULTU: begin
                {pend_hi, pend_lo} <= prod_u;
                pend_wr <= 1'b1;
                cnt     <= 4'(MUL_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV: begin
                pend_lo <= quo_s[31:0];
                pend_hi <= rem_s[31:0];
                pend_wr <= !div_zero;
                cnt     <= 4'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIVU: begin
                pend_lo <= quo_u;
                pend_hi <= rem_u;
                pend_wr <= !div_zero;
                cnt     <= 4'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table, hand-written stall/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;

  int vecs = 0;
  int errs = 0;
  logic allow_run_start = 1'b0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .d_is_md(d_is_md),
    .busy(busy), .hi(hi), .lo(lo), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // A start pulse while busy is illegal except in the deliberate ignore test.
  always @(posedge clk) begin
    if (!allow_run_start && reset === 1'b1)
      assert (!(start === 1'b1 && busy === 1'b1))
      else $error("FAIL start_in_run: got start=1 busy=1 expected no start while busy");
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [2:0] op);
    if (op <= 3'd1) return 5;
    if (op <= 3'd3) return 10;
    return 0;
  endfunction

  // Architectural reference: what HI/LO hold after the operation completes.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     w;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    case (op)
      3'd0: begin w = sa * sb; h = w[63:32]; l = w[31:0]; end
      3'd1: begin p = ua * ub; w = p; h = w[63:32]; l = w[31:0]; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        w = q; l = w[31:0];
        w = r; h = w[31:0];
      end
      3'd3: if (b != 0) begin l = a / b; h = a % b; end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  // Issue one operation, scramble the operand buses, and count busy cycles.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    md_op = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; md_op = 3'($urandom_range(0, 7));
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cyc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cyc;
    logic [2:0]  op;
    logic [31:0] a, b;

    tbl[0]  = '{3'd5, 32'h12345678, 32'h0,        32'h0,        32'h12345678, 0};
    tbl[1]  = '{3'd0, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    tbl[2]  = '{3'd1, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
    tbl[3]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    tbl[4]  = '{3'd3, 32'h7,        32'h2,        32'h1,        32'h3,        10};
    tbl[5]  = '{3'd4, 32'hAAAA0000, 32'h0,        32'hAAAA0000, 32'h3,        0};
    tbl[6]  = '{3'd5, 32'h0000BBBB, 32'h0,        32'hAAAA0000, 32'h0000BBBB, 0};
    tbl[7]  = '{3'd2, 32'h5,        32'h0,        32'hAAAA0000, 32'h0000BBBB, 10};
    tbl[8]  = '{3'd3, 32'h5,        32'h0,        32'hAAAA0000, 32'h0000BBBB, 10};
    tbl[9]  = '{3'd6, 32'h11111111, 32'h2,        32'hAAAA0000, 32'h0000BBBB, 0};
    tbl[10] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
    tbl[11] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};

    reset = 1'b0; start = 1'b0; md_op = '0; src_a = '0; src_b = '0; d_is_md = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
      chk($sformatf("vec%0d_hi", i), hi, tbl[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), lo, tbl[i].exp_lo);
    end
    ref_hi = hi; ref_lo = lo;
    ref_hi = tbl[11].exp_hi; ref_lo = tbl[11].exp_lo;

    // Stall interface with decode using HI/LO
    @(negedge clk);
    d_is_md = 1'b1; md_op = 3'd0; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    #1 chk("stall_start_cycle", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_busy%0d", i + 1), 32'(stall_req), 32'd1);
      @(posedge clk); #2;
    end
    chk("stall_done_busy", 32'(busy), 32'd0);
    chk("stall_done_req", 32'(stall_req), 32'd0);
    chk("stall_done_lo", lo, 32'd6);
    chk("stall_done_hi", hi, 32'd0);

    // Decode not using the unit never stalls
    @(negedge clk);
    d_is_md = 1'b0; md_op = 3'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    #1 chk("nostall_start_cycle", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("nostall_cycle%0d", i + 1), 32'(stall_req), 32'd0);
      @(posedge clk); #2;
    end
    chk("nostall_lo", lo, 32'd81);

    // A start pulse during RUN is ignored
    allow_run_start = 1'b1;
    @(negedge clk);
    md_op = 3'd0; src_a = 32'd4; src_b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      cyc++;
      if (cyc == 2) begin
        @(negedge clk);
        md_op = 3'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    allow_run_start = 1'b0;
    chk("runstart_cycles", 32'(cyc), 32'd5);
    chk("runstart_hi", hi, 32'd0);
    chk("runstart_lo", lo, 32'd20);
    repeat (12) @(posedge clk);
    #1;
    chk("runstart_no_second_op", lo, 32'd20);

    // Asynchronous reset in busy cycle 4 of a DIV
    @(negedge clk);
    md_op = 3'd2; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midreset_busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("postreset_busy", 32'(busy), 32'd0);
    chk("postreset_hi", hi, 32'h0);
    chk("postreset_lo", lo, 32'h0);
    ref_hi = '0; ref_lo = '0;

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      model(op, a, b, ref_hi, ref_lo);
      run_op(op, a, b, cyc);
      chk($sformatf("rand%0d_op%0d_cycles", i, op), 32'(cyc), 32'(exp_cycles(op)));
      chk($sformatf("rand%0d_op%0d_hi", i, op), hi, ref_hi);
      chk($sformatf("rand%0d_op%0d_lo", i, op), lo, ref_lo);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the execute stage of the five-stage pipeline. It accepts one operation per start pulse from the ID/EX register outputs and owns the HI/LO registers. It holds `busy` for a fixed latency and drives the stall request back to decode, which converts the decode-stage instruction into a bubble in ID/EX. It is the producer end of the pipeline's stall interface.

## Interface
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO; one-cycle qualifier.
- `md_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- `src_a`  in  32  rs operand, already forwarded.
- `src_b`  in  32  rt operand, already forwarded.
- `d_is_md`  in  1  decode-stage instruction uses the unit (any md_op, or MFHI/MFLO).
- `busy`  out  1  multi-cycle operation in progress.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `stall_req`  out  1  `d_is_md & (busy | start_mc)`. `start_mc` is `start` with `md_op` in 0–3. Combinational.

## Operation
- Reset, while low and asynchronously:
  - `busy`=0, `hi`=0, `lo`=0, counter=0, pending result=0.
  - An in-flight operation is discarded. HI/LO are not written.
- Two states, IDLE and RUN. Counter is 4 bits and loaded with the latency.
- In IDLE, with `start`=1 sampled at a rising edge:
  - MULT: pending {hi,lo} = signed 64-bit product `src_a*src_b`. Counter = `MUL_CYCLES`. Go to RUN.
  - MULTU: pending = unsigned 64-bit product. Counter = `MUL_CYCLES`. Go to RUN.
  - DIV: pending lo = signed quotient (truncates toward zero), pending hi = remainder (sign of dividend). Counter = `DIV_CYCLES`. Go to RUN.
  - DIVU: pending lo = unsigned quotient, pending hi = unsigned remainder. Counter = `DIV_CYCLES`. Go to RUN.
  - MTHI: `hi` <= `src_a` at that edge. Stay IDLE.
  - MTLO: `lo` <= `src_a` at that edge. Stay IDLE.
  - Reserved op: no effect. Stay IDLE.
- In RUN, each edge decrements the counter. At the edge where the counter equals 1:
  - `hi`/`lo` <= pending result.
  - Counter goes to 0, `busy` goes to 0, return to IDLE.
- `busy` = 1 exactly in RUN.
- In RUN, `start` is ignored. Decode stall makes this unreachable; the assertion in the bench flags it.
- Division boundaries:
  - Divisor 0, DIV or DIVU: operation runs the full latency. HI/LO are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are captured at the start edge. Later changes on `src_a`/`src_b` have no effect.

## Timing
- The start edge is E0. `busy` is high from after E0 through the cycle ending at edge E(N), where N = `MUL_CYCLES` or `DIV_CYCLES`.
- `hi`/`lo` show the new result after E(N), in the same cycle `busy` is first low.
- MFHI/MFLO in decode stalls while `busy`, and also in the start cycle itself, because `start_mc` is included in `stall_req`. After the stall it reads the final value.
- MTHI/MTLO latency is 1 edge. They never assert `busy`.
- `stall_req` has zero latency and is purely combinational from its inputs and `busy`.
- Reset asserted mid-RUN: `busy` falls immediately, without waiting for a clock edge.
- Reset deassertion: the first rising edge after `reset` goes high may sample `start`.

## Test plan
- Reset state:
  - Stimulus: hold `reset`=0, then release.
  - Required: `busy`=0, `hi`=`lo`=0.
  - Stimulus: `start` MTLO with src_a=0x12345678.
  - Required: `lo`=0x12345678 after 1 edge; `busy` stays 0.
- MULT signed:
  - Stimulus: MULT with 0xFFFFFFFE, 0x00000003.
  - Required: `busy` high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Stimulus: MULTU with the same operands.
  - Required: hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed:
  - Stimulus: DIV -7 / 2.
  - Required: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIVU 7 / 2.
  - Required: lo=3, hi=1.
- Division boundaries:
  - Stimulus: DIV by 0 with hi=0xAAAA0000, lo=0x0000BBBB preloaded via MTHI/MTLO.
  - Required: both unchanged after the 10 busy cycles.
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required: lo=0x80000000, hi=0.
- Stall interface:
  - Stimulus: `d_is_md`=1 during MULT start and for the following cycles.
  - Required: `stall_req`=1 in the start cycle and all 5 busy cycles, then 0 in the first cycle `busy`=0.
  - Stimulus: `d_is_md`=0.
  - Required: `stall_req`=0 throughout.
  - Stimulus: `start` pulse during RUN.
  - Required: ignored; results are those of the first operation.
- Reset mid-operation:
  - Stimulus: start DIV, assert `reset` low asynchronously on busy cycle 4.
  - Required: `busy`=0 and hi=lo=0 without waiting for a clock edge; no late write after `reset` releases.
